// File: rtl/core_pkg.sv
// Shared definitions for the core sequencer: one-hot phase codes, instruction
// classes, memory latency bound and the registered strobe bundle.
package core_pkg;

  localparam int MEM_LAT_MAX = 7;

  // One-hot phase codes; bit 7 is deliberately unused.
  typedef enum logic [9:0] {
    PH_START  = 10'h001,
    PH_WAIT   = 10'h002,
    PH_FETCH  = 10'h004,
    PH_DECODE = 10'h008,
    PH_EXEC   = 10'h010,
    PH_FPEXEC = 10'h020,
    PH_WRITE  = 10'h040,
    PH_LOAD   = 10'h100,
    PH_STORE  = 10'h200
  } phase_t;

  typedef enum logic [2:0] {
    OP_ALU   = 3'd0,
    OP_FPU   = 3'd1,
    OP_LOAD  = 3'd2,
    OP_STORE = 3'd3,
    OP_JUMP  = 3'd4,
    OP_HALT  = 3'd5
  } op_class_t;

  typedef struct packed {
    logic fetch_en;
    logic decode_en;
    logic exec_en;
    logic fpu_start;
    logic wb_en;
    logic mem_en;
    logic mem_we;
    logic pc_inc;
    logic pc_load;
    logic halted;
  } strobes_t;

  // Strobe values for the phase about to be entered, so they line up with mode.
  function automatic strobes_t strobes_for(phase_t nxt, logic entry, logic jump_entry);
    strobes_t s;
    s           = '0;
    s.fetch_en  = (nxt == PH_FETCH);
    s.decode_en = (nxt == PH_DECODE);
    s.exec_en   = (nxt == PH_EXEC);
    s.fpu_start = (nxt == PH_FPEXEC) && entry;
    s.wb_en     = (nxt == PH_WRITE);
    s.mem_en    = (nxt == PH_LOAD) || (nxt == PH_STORE);
    s.mem_we    = (nxt == PH_STORE);
    s.pc_inc    = (nxt == PH_WRITE) || (nxt == PH_STORE);
    s.pc_load   = (nxt == PH_EXEC) && jump_entry;
    s.halted    = (nxt == PH_WAIT);
    return s;
  endfunction

endpackage

// File: rtl/lat_timer.sv
// Loadable 3-bit down-counter; done is high once the count has reached zero.
module lat_timer (
  input  logic       clk,
  input  logic       rstn,
  input  logic       load,
  input  logic [2:0] value,
  output logic       done
);

  logic [2:0] count;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      count <= '0;
    else if (load)
      count <= value;
    else if (count != 3'd0)
      count <= count - 3'd1;
  end

  assign done = (count == 3'd0);

endmodule

// File: rtl/core_seq.sv
// Instruction-phase sequencer: steps START/FETCH/DECODE/execute phases and
// emits registered one-hot mode plus unit strobes aligned with it.
module core_seq
  import core_pkg::*;
#(
  parameter int START_WAIT = 11,
  parameter int MEM_LAT    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        run,
  input  logic [2:0]  op_class,
  input  logic        fpu_done,
  output logic [9:0]  mode,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        exec_en,
  output logic        fpu_start,
  output logic        wb_en,
  output logic        mem_en,
  output logic        mem_we,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] instret
);

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

  phase_t     state, nxt, boundary;
  logic [9:0] start_cnt;
  logic       jump, need_low, retire, tmr_done;
  strobes_t   strb;

  // Timer reloads in every phase except the two that consume it.
  lat_timer u_timer (
    .clk   (clk),
    .rstn  (rstn),
    .load  (state != PH_FETCH && state != PH_LOAD),
    .value (LAT_LOAD),
    .done  (tmr_done)
  );

  assign boundary = run ? PH_FETCH : PH_WAIT;
  assign retire   = (state == PH_WRITE) || (state == PH_STORE) || (state == PH_EXEC && jump);

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    nxt = state;
    case (state)
      PH_START:  if (start_cnt == 10'(START_WAIT)) nxt = boundary;
      PH_WAIT:   if (run && !need_low) nxt = PH_FETCH;
      PH_FETCH:  if (tmr_done) nxt = PH_DECODE;
      PH_DECODE: begin
        case (op_class)
          OP_ALU, OP_JUMP: nxt = PH_EXEC;
          OP_FPU:          nxt = PH_FPEXEC;
          OP_LOAD:         nxt = PH_LOAD;
          OP_STORE:        nxt = PH_STORE;
          default:         nxt = PH_WAIT;
        endcase
      end
      PH_EXEC:   nxt = jump ? boundary : PH_WRITE;
      PH_FPEXEC: if (fpu_done) nxt = PH_WRITE;
      PH_LOAD:   if (tmr_done) nxt = PH_WRITE;
      PH_STORE,
      PH_WRITE:  nxt = boundary;
      default:   nxt = PH_START;
    endcase
  end

  // NOTE: registered outputs are cleared by the async reset, so strobes drop without a clock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= PH_START;
      start_cnt <= '0;
      jump      <= 1'b0;
      need_low  <= 1'b0;
      illegal   <= 1'b0;
      instret   <= '0;
      strb      <= '0;
    end else begin
      state <= nxt;
      strb  <= strobes_for(nxt, state != nxt, state == PH_DECODE && op_class == OP_JUMP);
      if (state == PH_START && nxt == PH_START)
        start_cnt <= start_cnt + 10'd1;
      if (state == PH_DECODE) begin
        jump <= (op_class == OP_JUMP);
        if (nxt == PH_WAIT)
          need_low <= 1'b1;
        if (op_class > 3'(OP_HALT))
          illegal <= 1'b1;
      end
      // After HALT/illegal, WAIT must see run low before it may restart.
      if (state == PH_WAIT && !run)
        need_low <= 1'b0;
      if (retire)
        instret <= instret + 32'd1;
    end
  end

  assign mode      = state;
  assign fetch_en  = strb.fetch_en;
  assign decode_en = strb.decode_en;
  assign exec_en   = strb.exec_en;
  assign fpu_start = strb.fpu_start;
  assign wb_en     = strb.wb_en;
  assign mem_en    = strb.mem_en;
  assign mem_we    = strb.mem_we;
  assign pc_inc    = strb.pc_inc;
  assign pc_load   = strb.pc_load;
  assign halted    = strb.halted;

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq: reset, START timing, ALU/FPU/LOAD/STORE/JUMP
// flows, illegal restart rule, instret wrap and async reset mid-instruction.
module tb_core_seq;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rstn, run, fpu_done;
  logic [2:0]  op_class;
  logic [9:0]  mode;
  logic        fetch_en, decode_en, exec_en, fpu_start, wb_en;
  logic        mem_en, mem_we, pc_inc, pc_load, halted, illegal;
  logic [31:0] instret;

  int n_checks = 0;
  int n_errors = 0;
  int fp_cyc, fs_cnt;

  always #5 clk = ~clk;

  core_seq #(.START_WAIT(11), .MEM_LAT(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .run       (run),
    .op_class  (op_class),
    .fpu_done  (fpu_done),
    .mode      (mode),
    .fetch_en  (fetch_en),
    .decode_en (decode_en),
    .exec_en   (exec_en),
    .fpu_start (fpu_start),
    .wb_en     (wb_en),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .halted    (halted),
    .illegal   (illegal),
    .instret   (instret)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clocks; outputs are sampled and inputs driven 1ns after the edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; run = 1'b1; fpu_done = 1'b0; op_class = OP_ALU;
    #12;
    check("rst_mode", 32'(mode), 32'(PH_START));
    check("rst_instret", instret, 32'd0);
    check("rst_outs", 32'({fetch_en, decode_en, exec_en, fpu_start, wb_en, mem_en,
                            mem_we, pc_inc, pc_load, halted, illegal}), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // START runs 12 cycles, then FETCH for 2 cycles
    step(11);
    check("start_hold", 32'({mode, fetch_en}), 32'({PH_START, 1'b0}));
    step();
    check("fetch_cycle12", 32'({mode, fetch_en}), 32'({PH_FETCH, 1'b1}));
    step();
    check("fetch_2nd", 32'({mode, fetch_en}), 32'({PH_FETCH, 1'b1}));

    // ALU: DECODE, EXEC, WRITE, retire
    step();
    check("alu_decode", 32'({mode, decode_en}), 32'({PH_DECODE, 1'b1}));
    step();
    check("alu_exec", 32'({mode, exec_en, pc_load}), 32'({PH_EXEC, 2'b10}));
    step();
    check("alu_write", 32'({mode, wb_en, pc_inc}), 32'({PH_WRITE, 2'b11}));
    check("alu_instret_pre", instret, 32'd0);
    op_class = OP_FPU;
    step();
    check("alu_next_fetch", 32'({mode, wb_en, pc_inc}), 32'({PH_FETCH, 2'b00}));
    check("alu_instret", instret, 32'd1);

    // FPU: fpu_done during FETCH ignored, FPEXEC lasts 7 cycles
    fpu_done = 1'b1;
    step();
    fpu_done = 1'b0;
    check("fpu_done_in_fetch", 32'(mode), 32'(PH_FETCH));
    step();
    check("fpu_decode", 32'(mode), 32'(PH_DECODE));
    step();
    check("fpu_entry", 32'({mode, fpu_start}), 32'({PH_FPEXEC, 1'b1}));
    op_class = OP_LOAD;
    fp_cyc = 1; fs_cnt = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (mode == PH_FPEXEC) fp_cyc++;
      if (fpu_start) fs_cnt++;
    end
    fpu_done = 1'b1;
    step();
    fpu_done = 1'b0;
    check("fpu_write", 32'({mode, wb_en}), 32'({PH_WRITE, 1'b1}));
    check("fpexec_len", 32'(fp_cyc), 32'd7);
    check("fpu_start_once", 32'(fs_cnt), 32'd1);
    step();
    check("fpu_instret", instret, 32'd2);

    // LOAD with run dropped mid-instruction, then parked STORE
    step(2);
    step();
    check("load_1", 32'({mode, mem_en, mem_we}), 32'({PH_LOAD, 2'b10}));
    run = 1'b0;
    step();
    check("load_2", 32'({mode, mem_en}), 32'({PH_LOAD, 1'b1}));
    step();
    check("load_write", 32'({mode, wb_en, pc_inc}), 32'({PH_WRITE, 2'b11}));
    op_class = OP_STORE;
    step();
    check("load_wait", 32'({mode, halted}), 32'({PH_WAIT, 1'b1}));
    check("load_instret", instret, 32'd3);
    step(3);
    check("wait_parked", 32'({mode, fetch_en, halted}), 32'({PH_WAIT, 2'b01}));
    run = 1'b1;
    step();
    check("wait_to_fetch", 32'({mode, fetch_en, halted}), 32'({PH_FETCH, 2'b10}));
    step(3);
    check("store", 32'({mode, mem_en, mem_we, pc_inc}), 32'({PH_STORE, 3'b111}));
    op_class = 3'd7;
    step();
    check("store_next", 32'({mode, mem_en}), 32'({PH_FETCH, 1'b0}));
    check("store_instret", instret, 32'd4);

    // Illegal op: WAIT, sticky flag, needs run toggle
    step(3);
    check("illegal_wait", 32'({mode, halted, illegal}), 32'({PH_WAIT, 2'b11}));
    check("illegal_instret", instret, 32'd4);
    step(3);
    check("illegal_run_high", 32'(mode), 32'(PH_WAIT));
    run = 1'b0;
    step();
    check("illegal_run_low", 32'(mode), 32'(PH_WAIT));
    run = 1'b1;
    step();
    check("illegal_restart", 32'({mode, illegal}), 32'({PH_FETCH, 1'b1}));

    // JUMP with instret at all-ones wraps to zero
    force dut.instret = 32'hFFFF_FFFF;
    op_class = OP_JUMP;
    #1;
    release dut.instret;
    step(2);
    step();
    check("jump_exec", 32'({mode, exec_en, pc_load}), 32'({PH_EXEC, 2'b11}));
    check("jump_instret_pre", instret, 32'hFFFF_FFFF);
    op_class = OP_FPU;
    step();
    check("jump_next", 32'({mode, pc_load, wb_en}), 32'({PH_FETCH, 2'b00}));
    check("instret_wrap", instret, 32'd0);

    // Async reset in FPEXEC, then full START restart
    step(3);
    check("fpexec_again", 32'({mode, fpu_start}), 32'({PH_FPEXEC, 1'b1}));
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_mode", 32'(mode), 32'(PH_START));
    check("async_rst_outs", 32'({fetch_en, decode_en, exec_en, fpu_start, wb_en, mem_en,
                                  mem_we, pc_inc, pc_load, halted, illegal}), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    step(11);
    check("restart_start", 32'(mode), 32'(PH_START));
    step();
    check("restart_fetch", 32'({mode, fetch_en}), 32'({PH_FETCH, 1'b1}));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
